// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Receives a framed byte stream (LEN_LO, LEN_HI, N*4 payload bytes, CHK),
// assembles little-endian 32-bit words, and writes each word at byte address
// word_idx*4. It holds the core in reset until a frame passes its XOR checksum.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // word_idx is one bit wider than a word address so it can count up to MAX_WORDS
  localparam int IDX_W = ADDR_W - 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        len_lo;
  logic [15:0]       word_cnt;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        byte_cnt;
  logic [7:0]        checksum;
  logic [23:0]       asm_word;
  logic [TMR_W-1:0]  idle_cnt;
  logic              accept;
  logic              restart;
  logic              len_bad;
  logic              last_word;
  logic              timeout_hit;

  assign len_bad     = ({in_data, len_lo} == 16'd0) || ({in_data, len_lo} > 16'(MAX_WORDS));
  assign last_word   = ((16'(word_idx) + 16'd1) == word_cnt);
  assign timeout_hit = (idle_cnt == TMR_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, handshake and status outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    restart    = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          restart    = 1'b1;
          state_next = S_LEN_LO;
        end
      end
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHK: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (!in_valid) begin
          if (timeout_hit) begin
            state_next = S_ERR;
          end
        end else begin
          case (state)
            S_LEN_LO: state_next = S_LEN_HI;
            S_LEN_HI: state_next = len_bad ? S_ERR : S_DATA;
            S_DATA: begin
              if (byte_cnt == 2'd3 && last_word) begin
                state_next = S_CHK;
              end
            end
            S_CHK:    state_next = (in_data == checksum) ? S_DONE : S_ERR;
            default:  state_next = state;
          endcase
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (state == S_DONE) begin
      cpu_hold = 1'b0;
      done     = 1'b1;
    end
    if (state == S_ERR) begin
      error = 1'b1;
    end
  end

  // Datapath: length capture, word assembly, checksum, idle timer and write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_lo   <= '0;
      word_cnt <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      checksum <= '0;
      asm_word <= '0;
      idle_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (restart) begin
        word_idx <= '0;
        byte_cnt <= '0;
        checksum <= '0;
        asm_word <= '0;
        idle_cnt <= '0;
      end
      if (in_ready) begin
        idle_cnt <= accept ? '0 : idle_cnt + TMR_W'(1);
      end
      if (accept) begin
        case (state)
          S_LEN_LO: len_lo   <= in_data;
          S_LEN_HI: word_cnt <= {in_data, len_lo};
          S_DATA: begin
            checksum <= checksum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_addr  <= {word_idx[ADDR_W-3:0], 2'b00};
              wr_data  <= {in_data, asm_word};
              word_idx <= word_idx + IDX_W'(1);
            end else begin
              asm_word[{byte_cnt, 3'b000} +: 8] <= in_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 256;
  localparam int TIMEOUT   = 16;

  typedef logic [7:0] bytes_t[$];

  logic              clk      = 1'b0;
  logic              reset    = 1'b0;
  logic              start    = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int checks     = 0;
  int errors     = 0;
  int cycle      = 0;
  bit run_checks = 1'b0;

  // reference model state: position within the frame rather than a state machine
  bit                m_loading;
  int                m_pos;
  int                m_n;
  int                m_idle;
  int                m_k;
  int                m_result;
  logic [7:0]        m_lo;
  logic [7:0]        m_xor;
  logic [7:0]        m_bytes [4];
  bit                m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [31:0]       m_wr_data;

  int                wlog_cycle[$];
  logic [ADDR_W-1:0] wlog_addr[$];
  logic [31:0]       wlog_data[$];
  logic [31:0]       wq[$];

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(MAX_WORDS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Reference model: consumes the same inputs the DUT sees on each rising edge
  always @(posedge clk) begin
    cycle++;
    if (!reset) begin
      m_loading = 1'b0;
      m_pos     = 0;
      m_n       = 0;
      m_idle    = 0;
      m_result  = 0;
      m_xor     = 8'h00;
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      m_wr_data = '0;
    end else begin
      m_wr_en = 1'b0;
      if (!m_loading) begin
        if (start) begin
          m_loading = 1'b1;
          m_pos     = 0;
          m_xor     = 8'h00;
          m_idle    = 0;
          m_result  = 0;
        end
      end else if (in_valid) begin
        m_idle = 0;
        if (m_pos == 0) begin
          m_lo = in_data;
        end else if (m_pos == 1) begin
          m_n = int'({in_data, m_lo});
          if (m_n == 0 || m_n > MAX_WORDS) begin
            m_loading = 1'b0;
            m_result  = 2;
          end
        end else if (m_pos < 2 + 4 * m_n) begin
          m_k = m_pos - 2;
          m_xor ^= in_data;
          m_bytes[m_k % 4] = in_data;
          if (m_k % 4 == 3) begin
            m_wr_en   = 1'b1;
            m_wr_addr = ADDR_W'((m_k / 4) * 4);
            m_wr_data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          end
        end else begin
          m_result  = (in_data == m_xor) ? 1 : 2;
          m_loading = 1'b0;
        end
        m_pos++;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_loading = 1'b0;
          m_result  = 2;
        end
      end
    end
  end

  // Compare process: every output against the model, away from the active edge
  always @(negedge clk) begin
    if (run_checks) begin
      checkOutput("in_ready", 32'(in_ready), 32'(m_loading));
      checkOutput("wr_en",    32'(wr_en),    32'(m_wr_en));
      checkOutput("wr_addr",  32'(wr_addr),  32'(m_wr_addr));
      checkOutput("wr_data",  wr_data,       m_wr_data);
      checkOutput("cpu_hold", 32'(cpu_hold), 32'(m_result != 1));
      checkOutput("done",     32'(done),     32'(m_result == 1));
      checkOutput("error",    32'(error),    32'(m_result == 2));
    end
  end

  // Write log used by the directed literal checks
  always @(negedge clk) begin
    if (wr_en) begin
      wlog_cycle.push_back(cycle);
      wlog_addr.push_back(wr_addr);
      wlog_data.push_back(wr_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    wlog_cycle.delete();
    wlog_addr.delete();
    wlog_data.delete();
  endtask

  function automatic bytes_t makeFrame(input int n, input logic [31:0] words[$], input logic [7:0] chk_flip);
    bytes_t      f;
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    f.push_back(8'(n));
    f.push_back(8'(n >> 8));
    foreach (words[i]) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        f.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
    f.push_back(x ^ chk_flip);
    return f;
  endfunction

  // Pulse start, then send frame bytes; stops early once the loader refuses bytes
  task automatic applyStimulus(input bytes_t frame, input int max_gap, input int stall_at,
                               input int stall_len, input int start_at);
    int gap;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < frame.size(); i++) begin
      gap = (i == stall_at) ? stall_len : int'($urandom_range(max_gap, 0));
      in_valid = 1'b0;
      if (gap > 0) tick(gap);
      in_valid = 1'b1;
      in_data  = frame[i];
      start    = (i == start_at);
      @(negedge clk);
      if (!in_ready) begin
        in_valid = 1'b0;
        start    = 1'b0;
        break;
      end
      tick(1);
      start = 1'b0;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    tick(1);
  endtask

  task automatic waitFinish();
    for (int i = 0; i < 20 && !(done || error); i++) tick(1);
    checkOutput("finish", 32'(done | error), 32'd1);
  endtask

  initial begin
    bytes_t fr;
    int     n;
    logic [7:0] flip;

    tick(3);
    run_checks = 1'b1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_wr_addr",  32'(wr_addr),  32'd0);
    reset = 1'b1;
    tick(2);

    // single word, correct checksum
    clearLog();
    wq.delete();
    wq.push_back(32'h00000013);
    applyStimulus(makeFrame(1, wq, 8'h00), 0, -1, 0, -1);
    waitFinish();
    checkOutput("s1_wr_count", 32'(wlog_addr.size()), 32'd1);
    if (wlog_addr.size() > 0) begin
      checkOutput("s1_wr_addr", 32'(wlog_addr[0]), 32'h000);
      checkOutput("s1_wr_data", wlog_data[0], 32'h00000013);
    end
    checkOutput("s1_done",     32'(done),     32'd1);
    checkOutput("s1_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("s1_error",    32'(error),    32'd0);

    // three words at full rate
    clearLog();
    wq.delete();
    wq.push_back(32'h00500093);
    wq.push_back(32'h00A00113);
    wq.push_back(32'h002081B3);
    applyStimulus(makeFrame(3, wq, 8'h00), 0, -1, 0, -1);
    waitFinish();
    checkOutput("s2_wr_count", 32'(wlog_addr.size()), 32'd3);
    if (wlog_addr.size() == 3) begin
      checkOutput("s2_addr0", 32'(wlog_addr[0]), 32'h000);
      checkOutput("s2_addr1", 32'(wlog_addr[1]), 32'h004);
      checkOutput("s2_addr2", 32'(wlog_addr[2]), 32'h008);
      checkOutput("s2_data2", wlog_data[2], 32'h002081B3);
      checkOutput("s2_gap01", 32'(wlog_cycle[1] - wlog_cycle[0]), 32'd4);
      checkOutput("s2_gap12", 32'(wlog_cycle[2] - wlog_cycle[1]), 32'd4);
    end
    checkOutput("s2_done", 32'(done), 32'd1);

    // bad checksum (0x12), then a good reload
    clearLog();
    wq.delete();
    wq.push_back(32'h00000013);
    applyStimulus(makeFrame(1, wq, 8'h01), 1, -1, 0, -1);
    waitFinish();
    checkOutput("s3_wr_count", 32'(wlog_addr.size()), 32'd1);
    checkOutput("s3_error",    32'(error),    32'd1);
    checkOutput("s3_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("s3_done",     32'(done),     32'd0);
    applyStimulus(makeFrame(1, wq, 8'h00), 1, -1, 0, -1);
    waitFinish();
    checkOutput("s3_reload_done", 32'(done), 32'd1);

    // illegal lengths 0 and 257
    clearLog();
    applyStimulus(makeFrame(0, wq, 8'h00), 0, -1, 0, -1);
    checkOutput("s4_len0_error", 32'(error), 32'd1);
    applyStimulus(makeFrame(257, wq, 8'h00), 0, -1, 0, -1);
    checkOutput("s4_len257_error", 32'(error), 32'd1);
    checkOutput("s4_wr_count", 32'(wlog_addr.size()), 32'd0);

    // idle timeout after the second payload byte: 16 cycles fails, 15 cycles survives
    clearLog();
    wq.delete();
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h12345678);
    applyStimulus(makeFrame(2, wq, 8'h00), 0, 4, TIMEOUT, -1);
    checkOutput("s5_timeout_error", 32'(error), 32'd1);
    checkOutput("s5_timeout_nowr",  32'(wlog_addr.size()), 32'd0);
    applyStimulus(makeFrame(2, wq, 8'h00), 0, 4, TIMEOUT - 1, -1);
    waitFinish();
    checkOutput("s5_stall15_done", 32'(done), 32'd1);
    checkOutput("s5_stall15_wr",   32'(wlog_addr.size()), 32'd2);

    // reset in the middle of DATA
    clearLog();
    fr = makeFrame(2, wq, 8'h00);
    while (fr.size() > 7) void'(fr.pop_back());
    applyStimulus(fr, 0, -1, 0, -1);
    checkOutput("s6_pre_wr", 32'(wlog_addr.size()), 32'd1);
    reset = 1'b0;
    tick(2);
    checkOutput("s6_in_ready", 32'(in_ready), 32'd0);
    checkOutput("s6_wr_en",    32'(wr_en),    32'd0);
    checkOutput("s6_wr_addr",  32'(wr_addr),  32'd0);
    checkOutput("s6_wr_data",  wr_data,       32'd0);
    checkOutput("s6_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("s6_done",     32'(done),     32'd0);
    checkOutput("s6_error",    32'(error),    32'd0);
    reset = 1'b1;
    tick(1);

    // start pulse mid-frame is ignored
    clearLog();
    applyStimulus(makeFrame(2, wq, 8'h00), 1, -1, 0, 5);
    waitFinish();
    checkOutput("s7_done",  32'(done), 32'd1);
    checkOutput("s7_wr",    32'(wlog_addr.size()), 32'd2);

    // randomized frames against the model
    for (int t = 0; t < 40; t++) begin
      n = int'($urandom_range(6, 1));
      wq.delete();
      for (int w = 0; w < n; w++) wq.push_back(32'($urandom));
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      if ($urandom_range(9, 0) == 0) begin
        n = ($urandom_range(1, 0) == 0) ? 0 : MAX_WORDS + int'($urandom_range(5, 1));
      end
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick(2);
      in_valid = 1'b0;
      applyStimulus(makeFrame(n, wq, flip), int'($urandom_range(3, 0)),
                    ($urandom_range(4, 0) == 0) ? int'($urandom_range(8, 2)) : -1,
                    int'($urandom_range(18, 12)), -1);
      tick(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that writes a program image into instruction memory before the single-cycle core runs. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word at the byte addresses the program counter later fetches. It also holds the core in reset until a frame passes its checksum. It is the writer side of the instruction-memory interface that the core only reads.

## Interface
Parameters:
- ADDR_W, 10, byte-address width of instruction memory; matches the 10-bit PC.
- MAX_WORDS, 256, largest accepted word count; must be at most 2^(ADDR_W-2).
- TIMEOUT, 1024, maximum idle cycles allowed between accepted bytes while a load is in progress.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  a byte is present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  byte address of the write; always word-aligned.
- wr_data  out  32  instruction word to write.
- cpu_hold  out  1  1 = keep the core in reset.
- done  out  1  load completed and checksum matched.
- error  out  1  load failed.

## Operation
- Frame format, in order:
  - LEN_LO, then LEN_HI: the word count N, 16-bit little-endian.
  - N×4 payload bytes, each word least-significant byte first.
  - CHK: one byte equal to the XOR of all payload bytes. Length bytes are not included.
- A byte is accepted on a rising edge where in_valid && in_ready.
- States and transitions:
  - IDLE: start → LEN_LO.
  - LEN_LO: on accept, capture the low byte → LEN_HI.
  - LEN_HI: on accept, form N. If N==0 or N>MAX_WORDS → ERR; otherwise → DATA.
  - DATA: on each accepted byte, shift into the assembly register at position byte_cnt (0..3) and XOR into the checksum. On the 4th byte, write the word and increment word_idx. After word N-1 is written → CHK.
  - CHK: on accept, compare the byte with the checksum. Equal → DONE; unequal → ERR.
  - DONE / ERR: terminal until start or reset. start clears word_idx, byte_cnt, checksum, done and error, sets cpu_hold=1, and → LEN_LO.
- in_ready is 1 only in LEN_LO, LEN_HI, DATA and CHK.
- Outputs per state:
  - cpu_hold is 1 in every state except DONE.
  - done is 1 only in DONE; error is 1 only in ERR.
- Write address: wr_addr = word_idx<<2. word_idx cannot wrap because N is limited to MAX_WORDS.
- Timeout: in LEN_LO, LEN_HI, DATA or CHK, a counter increments on every cycle with no accept and clears on an accept. When it reaches TIMEOUT → ERR. A partially assembled word is discarded and never written.
- start pulses in LEN_LO, LEN_HI, DATA or CHK are ignored.
- Reset (active-low) overrides everything, including mid-frame. After reset: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, all counters and the checksum 0.

## Timing
- wr_en is registered: it is high for exactly one cycle, the cycle after the edge that accepts the 4th byte of a word. wr_addr and wr_data are valid in that same cycle.
- Between writes, wr_en=0. wr_addr and wr_data hold their last values.
- in_ready stays 1 during the wr_en cycle. Back-to-back bytes at full rate are sustained with no bubbles, so a word may be accepted every 4 cycles.
- LEN_HI to DATA, the final data byte to CHK, and CHK to DONE/ERR each take one edge.
- done and cpu_hold change in the cycle after the CHK byte is accepted.
- Timeout → ERR takes effect on the edge where the counter reaches TIMEOUT. error goes high the next cycle.
- in_valid with in_ready=0 has no effect; the byte is not consumed.

## Test plan
- Reset, then start. Send 01 00, 13 00 00 00, then CHK 13 → one write: wr_addr=0x000, wr_data=0x00000013. Then done=1, cpu_hold=0, error=0.
- N=3 at full rate, words 0x00500093, 0x00A00113, 0x002081B3, correct CHK → writes at addresses 0x000/0x004/0x008, with wr_en spaced exactly 4 cycles apart. Then done=1.
- Same frame as the first scenario with CHK 0x12 → all writes still occur, then error=1, cpu_hold=1, done=0. A subsequent start followed by a correct frame → done=1.
- Length bytes 00 00, and separately 01 01 (N=257) → ERR after LEN_HI, with no wr_en.
- TIMEOUT=16: stall in_valid for 16 cycles after the 2nd payload byte → error=1, no write of the partial word. Repeat with a 15-cycle stall → the load completes normally.
- Assert reset in the middle of DATA, and separately pulse start in the middle of a frame → reset returns all outputs to reset values; the mid-frame start is ignored and the load completes normally.
